port_slot_scheduler: RTL
========================

# port_slot_scheduler

Per-port ready generator for the shared-memory switch: a parametrised successor to the existing ready logic, using the same slot-matching scheme. It owns the global slot counter and one slot register per destination port. It also adds an exclusive ownership lock per destination, lowest-index arbitration between requesters, and drop/error reporting. It sits between the input-port framers (vld/rx) and the shared-memory write path, and gates each port's write burst with `ready_out`.

## Interface
Parameters:
- PORT_NUB, 8, number of ports (≥2; non-power-of-two allowed)
- WIDTH_SEL, $clog2(PORT_NUB), port index / slot width (derived, not overridden)
- SLOT_OFFSET, 2, reset value of destination d's slot register is (d+SLOT_OFFSET) mod PORT_NUB

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- slot_en  in  1  advance slot counter this cycle
- vld_in  in  PORT_NUB  per-port frame valid, held high for the whole frame
- rx_in  in  PORT_NUB*WIDTH_SEL  per-port destination index, port i at bits [(i+1)*WIDTH_SEL-1 : i*WIDTH_SEL]
- ready_out  out  PORT_NUB  per-port grant/ready
- slot_cnt_out  out  WIDTH_SEL  current slot counter
- busy_out  out  PORT_NUB  destination d currently locked
- err_out  out  1  one-cycle pulse: rx_in out of range (≥PORT_NUB) while vld_in high

## Operation
- Slot counter slot_cnt:
  - resets to 0.
  - On slot_en it increments, wrapping PORT_NUB-1 → 0.
  - slot_cnt_d1 is slot_cnt registered one cycle (reset 0).
- Per-destination state: slot_reg[d] (reset (d+SLOT_OFFSET) mod PORT_NUB), lock[d] (reset 0), owner[d] (WIDTH_SEL, reset 0).
- Per-port state: vld_f[i] (reset 0), gnt[i] (reset 0), dst[i] (latched destination, reset 0).
- Request eligibility for port i with gnt[i]=0:
  - vld_in[i]=1, rx_in[i] < PORT_NUB, lock[rx]=0, and slot_reg[rx]==slot_cnt.
  - Among eligible ports with the same rx, only the lowest index i is selected.
- ready_out[i] = (gnt[i] & vld_in[i]) | selected[i]. It is combinational from registered state plus vld_in/rx_in.
- Grant (clock edge after selected[i]):
  - gnt[i]←1, dst[i]←rx_in[i], lock[rx]←1, owner[rx]←i.
  - rx_in changes while gnt[i]=1 are ignored; dst[i] holds.
- Release is triggered on the vld falling edge (vld_f[i]=1, vld_in[i]=0) with gnt[i]=1:
  - that cycle: slot_reg[dst[i]]←slot_cnt_d1, lock[dst[i]]←0.
  - gnt[i]←0.
  - A falling edge without a grant changes no state.
- Falling edge and new rising request on the same port in one cycle is impossible (one-cycle low minimum). A release and another port's request for the same destination in the same cycle: the request is not eligible that cycle (lock still 1).
- Simultaneous releases of different destinations are all processed in the same cycle.
- busy_out[d] = lock[d].
- err_out is registered: err_out ← |(vld_in[i] & rx_in[i] ≥ PORT_NUB). A port with an out-of-range rx is never granted.

## Timing
- Reset: ready_out=0, slot_cnt_out=0, busy_out=0, err_out=0. All state goes to the reset values above, asynchronously on rst_n low, including mid-frame. No release update occurs after reset.
- ready_out latency: 0 cycles from vld_in/rx_in when eligible. It stays high every cycle until vld_in falls, then drops combinationally in the same cycle.
- Lock and slot_reg update: 1 cycle after the falling-edge cycle. The freed destination is eligible on the following cycle only if slot_cnt equals the new slot_reg.
- slot_cnt_out changes 1 cycle after slot_en is sampled high.
- err_out: 1-cycle latency, width equals the number of offending cycles.

## Test plan
- Reset and counter, PORT_NUB=5:
  - After reset, slot_cnt_out=0, slot_reg=[2,3,4,0,1], ready_out=0.
  - 7 slot_en pulses → slot_cnt_out = 0,1,2,3,4,0,1,2 (one value per step).
- Single grant:
  - Port 0 vld with rx=1 while slot_cnt=3 → ready_out[0]=1 same cycle, busy_out[1]=1 next cycle.
  - Hold 4 cycles, drop vld with slot_cnt_d1=4 → ready_out[0]=0 same cycle, next cycle busy_out[1]=0, slot_reg[1]=4.
- Arbitration:
  - Ports 2, 4, 6 request rx=3 simultaneously with slot match → only ready_out[2]=1.
  - After port 2 releases and the slot matches again → port 4 is granted, never port 6 first.
- Lock:
  - Port 1 holds dst 5. Port 3 requests rx=5 while slot_reg[5]==slot_cnt → ready_out[3]=0 for the whole hold.
  - Port 1 changing rx_in mid-frame → dst and lock unchanged.
- Error path: port 0 vld with rx=6 (PORT_NUB=5) for 2 cycles → err_out high 2 cycles, one cycle delayed; ready_out[0]=0; no state change.
- Async reset mid-frame: assert rst_n low during port 0 grant → ready_out, busy_out, slot_cnt_out go to 0 immediately; after reset, slot_reg holds the reset values.

Source files
------------

// File: rtl/port_slot_scheduler.sv
// port_slot_scheduler: slot-matched per-port ready generator with per-destination ownership lock
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   slot_en        advance the global slot counter
//   vld_in/rx_in   per-port frame valid and destination index (WIDTH_SEL bits per port)
//   ready_out      per-port grant, combinational from registered state and vld_in/rx_in
//   slot_cnt_out   current slot counter
//   busy_out       per-destination lock
//   err_out        registered pulse: a valid port carries an out-of-range destination
module port_slot_scheduler #(
    parameter int PORT_NUB    = 8,
    parameter int WIDTH_SEL   = $clog2(PORT_NUB),
    parameter int SLOT_OFFSET = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          slot_en,
    input  logic [PORT_NUB-1:0]           vld_in,
    input  logic [PORT_NUB*WIDTH_SEL-1:0] rx_in,
    output logic [PORT_NUB-1:0]           ready_out,
    output logic [WIDTH_SEL-1:0]          slot_cnt_out,
    output logic [PORT_NUB-1:0]           busy_out,
    output logic                          err_out
);
    logic [WIDTH_SEL-1:0] slot_cnt;
    logic [WIDTH_SEL-1:0] slot_cnt_d1;
    logic [WIDTH_SEL-1:0] slot_reg [PORT_NUB];
    logic [WIDTH_SEL-1:0] owner    [PORT_NUB];
    logic [WIDTH_SEL-1:0] dst      [PORT_NUB];
    logic [WIDTH_SEL-1:0] rx       [PORT_NUB];
    logic [PORT_NUB-1:0]  lock;
    logic [PORT_NUB-1:0]  vld_f;
    logic [PORT_NUB-1:0]  gnt;
    logic [PORT_NUB-1:0]  sel;
    logic [PORT_NUB-1:0]  taken;
    logic [PORT_NUB-1:0]  rel;
    logic                 err_now;

    assign rel          = vld_f & ~vld_in & gnt;
    assign ready_out    = (gnt & vld_in) | sel;
    assign slot_cnt_out = slot_cnt;
    assign busy_out     = lock;

    // Ports are scanned in index order; taken marks a destination already
    // claimed this cycle so only the lowest requesting port wins it.
    // An out-of-range rx matches no destination and is therefore never selected.
    always_comb begin
        taken   = '0;
        sel     = '0;
        err_now = 1'b0;
        for (int i = 0; i < PORT_NUB; i++) begin
            rx[i]   = rx_in[i*WIDTH_SEL +: WIDTH_SEL];
            err_now = err_now | (vld_in[i] & (int'(rx[i]) >= PORT_NUB));
            for (int d = 0; d < PORT_NUB; d++)
                if (vld_in[i] && !gnt[i] && rx[i] == WIDTH_SEL'(d) && !lock[d] &&
                    !taken[d] && slot_reg[d] == slot_cnt) begin
                    sel[i]   = 1'b1;
                    taken[d] = 1'b1;
                end
        end
    end

    // Releases are applied before grants; a destination being released is
    // still locked this cycle, so no grant can target it in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt    <= '0;
            slot_cnt_d1 <= '0;
            lock        <= '0;
            vld_f       <= '0;
            gnt         <= '0;
            err_out     <= 1'b0;
            for (int d = 0; d < PORT_NUB; d++) begin
                slot_reg[d] <= WIDTH_SEL'((d + SLOT_OFFSET) % PORT_NUB);
                owner[d]    <= '0;
                dst[d]      <= '0;
            end
        end else begin
            if (slot_en)
                slot_cnt <= (slot_cnt == WIDTH_SEL'(PORT_NUB - 1)) ? '0 : slot_cnt + 1'b1;
            slot_cnt_d1 <= slot_cnt;
            vld_f       <= vld_in;
            err_out     <= err_now;
            for (int i = 0; i < PORT_NUB; i++)
                if (rel[i]) begin
                    gnt[i] <= 1'b0;
                    for (int d = 0; d < PORT_NUB; d++)
                        if (dst[i] == WIDTH_SEL'(d) && owner[d] == WIDTH_SEL'(i)) begin
                            slot_reg[d] <= slot_cnt_d1;
                            lock[d]     <= 1'b0;
                        end
                end
            for (int i = 0; i < PORT_NUB; i++)
                if (sel[i]) begin
                    gnt[i] <= 1'b1;
                    dst[i] <= rx[i];
                    for (int d = 0; d < PORT_NUB; d++)
                        if (rx[i] == WIDTH_SEL'(d)) begin
                            lock[d]  <= 1'b1;
                            owner[d] <= WIDTH_SEL'(i);
                        end
                end
        end
    end
endmodule
